hazard_controller: RTL and testbench

//  Sequences the instruction-decode stage of the 5-stage MIPS pipeline. Tracks in-flight destination

---
 rtl/hazard_pkg.sv | 38 +++
 rtl/hazard_controller_if.sv | 43 ++++
 rtl/hazard_scoreboard.sv | 36 +++
 rtl/hazard_controller.sv | 111 +++++++++++
 tb/tb_hazard_controller.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the ID-stage hazard controller: scoreboard slot layout,
// forwarding selects, controller states and the forwarding/match helpers.
package hazard_pkg;

   localparam int REG_ADDR_W = 5;

   typedef struct packed {
      logic                  reg_write;
      logic                  mem_read;
      logic [REG_ADDR_W-1:0] dest;
   } slot_t;

   typedef enum logic [1:0] {
      FWD_REG   = 2'b00,
      FWD_EXMEM = 2'b01,
      FWD_MEMWB = 2'b10
   } fwd_sel_e;

   typedef enum logic [1:0] {
      RUN,
      STALL,
      FROZEN
   } hz_state_e;

   localparam slot_t SLOT_EMPTY = '0;

   // $0 is hard-wired, so a producer targeting it never creates a dependency.
   function automatic logic slot_match(slot_t s, logic [REG_ADDR_W-1:0] r, logic used);
      return used && s.reg_write && (s.dest == r) && (r != '0);
   endfunction

   function automatic fwd_sel_e fwd_pick(logic mem_hit, logic mem_load, logic wb_hit);
      if (mem_hit && !mem_load) return FWD_EXMEM;
      if (wb_hit) return FWD_MEMWB;
      return FWD_REG;
   endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Decode-stage bundle between the pipeline datapath (master) and the hazard
// controller (slave).
interface hazard_controller_if #(parameter int COUNT_W = 32);
   import hazard_pkg::*;

   logic                  holdInput;
   logic [REG_ADDR_W-1:0] addressRsInput;
   logic [REG_ADDR_W-1:0] addressRtInput;
   logic                  usesRsInput;
   logic                  usesRtInput;
   logic                  branchInput;
   logic                  branchTakenInput;
   logic                  jumpInput;
   logic                  regWriteInput;
   logic                  memReadInput;
   logic [REG_ADDR_W-1:0] destRegInput;

   logic                  pcWriteOutput;
   logic                  ifIdWriteOutput;
   logic                  idExBubbleOutput;
   logic                  ifFlushOutput;
   fwd_sel_e              forwardRsOutput;
   fwd_sel_e              forwardRtOutput;
   logic [COUNT_W-1:0]    stallCountOutput;
   logic                  hazardErrorOutput;

   modport master (
      output holdInput, addressRsInput, addressRtInput, usesRsInput, usesRtInput,
             branchInput, branchTakenInput, jumpInput, regWriteInput, memReadInput,
             destRegInput,
      input  pcWriteOutput, ifIdWriteOutput, idExBubbleOutput, ifFlushOutput,
             forwardRsOutput, forwardRtOutput, stallCountOutput, hazardErrorOutput
   );

   modport slave (
      input  holdInput, addressRsInput, addressRtInput, usesRsInput, usesRtInput,
             branchInput, branchTakenInput, jumpInput, regWriteInput, memReadInput,
             destRegInput,
      output pcWriteOutput, ifIdWriteOutput, idExBubbleOutput, ifFlushOutput,
             forwardRsOutput, forwardRtOutput, stallCountOutput, hazardErrorOutput
   );

endinterface

// File: rtl/hazard_scoreboard.sv
// Three-slot EX/MEM/WB shadow of in-flight destinations; shifts each unheld
// cycle and inserts an empty slot when the ID instruction is bubbled.
module hazard_scoreboard
   import hazard_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  hold_i,
   input  logic  bubble_i,
   input  slot_t insert_i,
   output slot_t ex_o,
   output slot_t mem_o,
   output slot_t wb_o
);

   slot_t ex_q, mem_q, wb_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: slot contents are reset, not just a valid bit; a stale dest would match.
         ex_q  <= SLOT_EMPTY;
         mem_q <= SLOT_EMPTY;
         wb_q  <= SLOT_EMPTY;
      end else if (!hold_i) begin
         // NOTE: non-blocking so each slot takes its neighbour's pre-edge value.
         wb_q  <= mem_q;
         mem_q <= ex_q;
         ex_q  <= bubble_i ? SLOT_EMPTY : insert_i;
      end
   end

   assign ex_o  = ex_q;
   assign mem_o = mem_q;
   assign wb_o  = wb_q;

endmodule

// File: rtl/hazard_controller.sv
// ID-stage hazard controller: load-use / branch-operand stall detection,
// pipeline enables, branch-compare forwarding, stall accounting.
module hazard_controller
   import hazard_pkg::*;
#(
   parameter int COUNT_W   = 32,
   parameter int MAX_STALL = 2
) (
   input logic                clk,
   input logic                reset,
   hazard_controller_if.slave hz
);

   localparam int                  CONSEC_W   = $clog2(MAX_STALL + 2);
   localparam logic [CONSEC_W-1:0] CONSEC_MAX = CONSEC_W'(MAX_STALL + 1);

   slot_t ex_s, mem_s, wb_s, insert_s;
   logic  rs_ex, rt_ex, rs_mem, rt_mem, rs_wb, rt_wb;
   logic  stall;

   hz_state_e           state_q, state_d;
   logic [CONSEC_W-1:0] consec_q, consec_d;
   logic [COUNT_W-1:0]  count_q, count_d;
   logic                error_q, error_d;

   assign insert_s = {hz.regWriteInput, hz.memReadInput, hz.destRegInput};

   hazard_scoreboard u_scoreboard (
      .clk      (clk),
      .rst_n    (reset),
      .hold_i   (hz.holdInput),
      .bubble_i (stall),
      .insert_i (insert_s),
      .ex_o     (ex_s),
      .mem_o    (mem_s),
      .wb_o     (wb_s)
   );

   assign rs_ex  = slot_match(ex_s,  hz.addressRsInput, hz.usesRsInput);
   assign rt_ex  = slot_match(ex_s,  hz.addressRtInput, hz.usesRtInput);
   assign rs_mem = slot_match(mem_s, hz.addressRsInput, hz.usesRsInput);
   assign rt_mem = slot_match(mem_s, hz.addressRtInput, hz.usesRtInput);
   assign rs_wb  = slot_match(wb_s,  hz.addressRsInput, hz.usesRsInput);
   assign rt_wb  = slot_match(wb_s,  hz.addressRtInput, hz.usesRtInput);

   // Branches compare in ID, so any EX producer or a load still in MEM is too late.
   assign stall = (ex_s.mem_read & (rs_ex | rt_ex))
                | (hz.branchInput & (rs_ex | rt_ex))
                | (hz.branchInput & mem_s.mem_read & (rs_mem | rt_mem));

   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
      hz.pcWriteOutput    = 1'b0;
      hz.ifIdWriteOutput  = 1'b0;
      hz.idExBubbleOutput = 1'b0;
      hz.ifFlushOutput    = 1'b0;
      hz.forwardRsOutput  = FWD_REG;
      hz.forwardRtOutput  = FWD_REG;
      if (!reset) begin
         hz.idExBubbleOutput = 1'b1;
      end else begin
         hz.forwardRsOutput = fwd_pick(rs_mem, mem_s.mem_read, rs_wb);
         hz.forwardRtOutput = fwd_pick(rt_mem, mem_s.mem_read, rt_wb);
         if (!hz.holdInput) begin
            if (stall) begin
               hz.idExBubbleOutput = 1'b1;
            end else begin
               hz.pcWriteOutput   = 1'b1;
               hz.ifIdWriteOutput = 1'b1;
               hz.ifFlushOutput   = hz.branchTakenInput | hz.jumpInput;
            end
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      consec_d = consec_q;
      count_d  = count_q;
      if (hz.holdInput) begin
         state_d = FROZEN;
      end else if (stall) begin
         state_d = STALL;
         if (state_q == RUN)                consec_d = CONSEC_W'(1);
         else if (consec_q != CONSEC_MAX)   consec_d = consec_q + CONSEC_W'(1);
         if (count_q != '1)                 count_d  = count_q + COUNT_W'(1);
      end else begin
         state_d  = RUN;
         consec_d = '0;
      end
      error_d = error_q | (consec_d > CONSEC_W'(MAX_STALL));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= RUN;
         consec_q <= '0;
         count_q  <= '0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         consec_q <= consec_d;
         count_q  <= count_d;
         error_q  <= error_d;
      end
   end

   assign hz.stallCountOutput  = count_q;
   assign hz.hazardErrorOutput = error_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: a driver queues hand-computed expectations
// per cycle; an independent monitor pops and compares on the falling edge.
module tb_hazard_controller;
   import hazard_pkg::*;

   typedef struct packed {
      logic [4:0] rs, rt;
      logic       urs, urt, br, tk, j, rw, mr;
      logic [4:0] dst;
   } id_t;

   typedef struct {
      logic       pc, ifid, bub, fl;
      logic [1:0] frs, frt;
      int         cnt;
      logic       err, err2;
      string      tag;
   } exp_t;

   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   hazard_controller_if #(.COUNT_W(32)) h ();
   hazard_controller_if #(.COUNT_W(32)) h2 ();

   hazard_controller #(.COUNT_W(32), .MAX_STALL(2)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (h)
   );

   // Each stall bubbles EX, so two back-to-back stalls is the natural ceiling;
   // a second instance with a lower threshold exercises the sticky error.
   hazard_controller #(.COUNT_W(32), .MAX_STALL(1)) dut_low (
      .clk   (clk),
      .reset (reset),
      .hz    (h2)
   );

   assign h2.holdInput        = h.holdInput;
   assign h2.addressRsInput   = h.addressRsInput;
   assign h2.addressRtInput   = h.addressRtInput;
   assign h2.usesRsInput      = h.usesRsInput;
   assign h2.usesRtInput      = h.usesRtInput;
   assign h2.branchInput      = h.branchInput;
   assign h2.branchTakenInput = h.branchTakenInput;
   assign h2.jumpInput        = h.jumpInput;
   assign h2.regWriteInput    = h.regWriteInput;
   assign h2.memReadInput     = h.memReadInput;
   assign h2.destRegInput     = h.destRegInput;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   function automatic id_t nop();
      return '0;
   endfunction

   function automatic id_t alu(int d, int s, int t);
      id_t i = '0;
      i.rs = 5'(s); i.rt = 5'(t); i.urs = 1'b1; i.urt = 1'b1;
      i.rw = 1'b1; i.dst = 5'(d);
      return i;
   endfunction

   function automatic id_t lw(int d, int s);
      id_t i = '0;
      i.rs = 5'(s); i.urs = 1'b1; i.rw = 1'b1; i.mr = 1'b1; i.dst = 5'(d);
      return i;
   endfunction

   function automatic id_t beq(int s, int t, logic taken);
      id_t i = '0;
      i.rs = 5'(s); i.rt = 5'(t); i.urs = 1'b1; i.urt = 1'b1;
      i.br = 1'b1; i.tk = taken;
      return i;
   endfunction

   function automatic id_t jmp();
      id_t i = '0;
      i.j = 1'b1;
      return i;
   endfunction

   function automatic exp_t ex_run(int cnt, logic e2, logic fl, logic [1:0] frs, logic [1:0] frt);
      exp_t e;
      e.pc = 1'b1; e.ifid = 1'b1; e.bub = 1'b0; e.fl = fl;
      e.frs = frs; e.frt = frt; e.cnt = cnt; e.err = 1'b0; e.err2 = e2; e.tag = "";
      return e;
   endfunction

   function automatic exp_t ex_stall(int cnt, logic e2);
      exp_t e = ex_run(cnt, e2, 1'b0, 2'b00, 2'b00);
      e.pc = 1'b0; e.ifid = 1'b0; e.bub = 1'b1;
      return e;
   endfunction

   function automatic exp_t ex_hold(int cnt, logic e2);
      exp_t e = ex_run(cnt, e2, 1'b0, 2'b00, 2'b00);
      e.pc = 1'b0; e.ifid = 1'b0;
      return e;
   endfunction

   function automatic exp_t ex_rst();
      exp_t e = ex_stall(0, 1'b0);
      return e;
   endfunction

   task automatic step(input string tag, input logic rst_v, input logic hold,
                       input id_t i, input exp_t e);
      @(posedge clk);
      #1;
      reset              = rst_v;
      h.holdInput        = hold;
      h.addressRsInput   = i.rs;
      h.addressRtInput   = i.rt;
      h.usesRsInput      = i.urs;
      h.usesRtInput      = i.urt;
      h.branchInput      = i.br;
      h.branchTakenInput = i.tk;
      h.jumpInput        = i.j;
      h.regWriteInput    = i.rw;
      h.memReadInput     = i.mr;
      h.destRegInput     = i.dst;
      e.tag = tag;
      exp_q.push_back(e);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check({mon_e.tag, ".pcWrite"},    32'(h.pcWriteOutput),     32'(mon_e.pc));
            check({mon_e.tag, ".ifIdWrite"},  32'(h.ifIdWriteOutput),   32'(mon_e.ifid));
            check({mon_e.tag, ".idExBubble"}, 32'(h.idExBubbleOutput),  32'(mon_e.bub));
            check({mon_e.tag, ".ifFlush"},    32'(h.ifFlushOutput),     32'(mon_e.fl));
            check({mon_e.tag, ".forwardRs"},  32'(h.forwardRsOutput),   32'(mon_e.frs));
            check({mon_e.tag, ".forwardRt"},  32'(h.forwardRtOutput),   32'(mon_e.frt));
            check({mon_e.tag, ".stallCount"}, h.stallCountOutput,       32'(mon_e.cnt));
            check({mon_e.tag, ".hazardError"},32'(h.hazardErrorOutput), 32'(mon_e.err));
            check({mon_e.tag, ".hazardErrorLow"}, 32'(h2.hazardErrorOutput), 32'(mon_e.err2));
         end
      end
   end

   initial begin
      reset              = 1'b0;
      h.holdInput        = 1'b0;
      h.addressRsInput   = '0;
      h.addressRtInput   = '0;
      h.usesRsInput      = 1'b0;
      h.usesRtInput      = 1'b0;
      h.branchInput      = 1'b0;
      h.branchTakenInput = 1'b0;
      h.jumpInput        = 1'b0;
      h.regWriteInput    = 1'b0;
      h.memReadInput     = 1'b0;
      h.destRegInput     = '0;

      step("rst0",     1'b0, 1'b0, alu(2, 1, 1),   ex_rst());
      step("rst1",     1'b0, 1'b1, alu(2, 1, 1),   ex_rst());
      // lw $2 ; add $3,$2,$4 -> one load-use stall
      step("lw2",      1'b1, 1'b0, lw(2, 1),       ex_run(0, 0, 0, 2'b00, 2'b00));
      step("lu_stall", 1'b1, 1'b0, alu(3, 2, 4),   ex_stall(0, 0));
      step("lu_go",    1'b1, 1'b0, alu(3, 2, 4),   ex_run(1, 0, 0, 2'b00, 2'b00));
      // add $2 ; beq $2,$5 taken -> one stall then EX/MEM forward and flush
      step("add2",     1'b1, 1'b0, alu(2, 6, 7),   ex_run(1, 0, 0, 2'b00, 2'b00));
      step("br_stall", 1'b1, 1'b0, beq(2, 5, 1),   ex_stall(1, 0));
      step("br_fwd",   1'b1, 1'b0, beq(2, 5, 1),   ex_run(2, 0, 1, 2'b01, 2'b00));
      step("br_after", 1'b1, 1'b0, nop(),          ex_run(2, 0, 0, 2'b00, 2'b00));
      // lw $2 ; beq $2,$0 -> two stalls then MEM/WB forward
      step("lw2b",     1'b1, 1'b0, lw(2, 1),       ex_run(2, 0, 0, 2'b00, 2'b00));
      step("lb_st1",   1'b1, 1'b0, beq(2, 0, 0),   ex_stall(2, 0));
      step("lb_st2",   1'b1, 1'b0, beq(2, 0, 0),   ex_stall(3, 0));
      step("lb_fwd",   1'b1, 1'b0, beq(2, 0, 0),   ex_run(4, 1, 0, 2'b10, 2'b00));
      // writes to $0 never create a dependency
      step("wr0",      1'b1, 1'b0, alu(0, 1, 1),   ex_run(4, 1, 0, 2'b00, 2'b00));
      step("rd0",      1'b1, 1'b0, beq(0, 0, 1),   ex_run(4, 1, 1, 2'b00, 2'b00));
      // two producers of $2: MEM wins over WB
      step("pa",       1'b1, 1'b0, alu(2, 1, 1),   ex_run(4, 1, 0, 2'b00, 2'b00));
      step("pb",       1'b1, 1'b0, alu(2, 3, 3),   ex_run(4, 1, 0, 2'b00, 2'b00));
      step("pnop",     1'b1, 1'b0, nop(),          ex_run(4, 1, 0, 2'b00, 2'b00));
      step("prio",     1'b1, 1'b0, beq(2, 2, 0),   ex_run(4, 1, 0, 2'b01, 2'b01));
      step("jump",     1'b1, 1'b0, jmp(),          ex_run(4, 1, 1, 2'b00, 2'b00));
      // hold during a load-use stall
      step("lw2c",     1'b1, 1'b0, lw(2, 1),       ex_run(4, 1, 0, 2'b00, 2'b00));
      step("hold1",    1'b1, 1'b1, alu(3, 2, 4),   ex_hold(4, 1));
      step("hold2",    1'b1, 1'b1, alu(3, 2, 4),   ex_hold(4, 1));
      step("hold3",    1'b1, 1'b1, alu(3, 2, 4),   ex_hold(4, 1));
      step("rel_st",   1'b1, 1'b0, alu(3, 2, 4),   ex_stall(4, 1));
      step("rel_go",   1'b1, 1'b0, alu(3, 2, 4),   ex_run(5, 1, 0, 2'b00, 2'b00));
      // async reset in the middle of a stall
      step("lw2d",     1'b1, 1'b0, lw(2, 1),       ex_run(5, 1, 0, 2'b00, 2'b00));
      step("pre_rst",  1'b1, 1'b0, alu(3, 2, 4),   ex_stall(5, 1));
      step("mid_rst0", 1'b0, 1'b0, beq(2, 0, 1),   ex_rst());
      step("mid_rst1", 1'b0, 1'b1, beq(2, 0, 1),   ex_rst());
      step("post_rst", 1'b1, 1'b0, beq(2, 0, 1),   ex_run(0, 0, 1, 2'b00, 2'b00));
      step("post_nop", 1'b1, 1'b0, nop(),          ex_run(0, 0, 0, 2'b00, 2'b00));

      repeat (3) @(negedge clk);
      #1;
      check("drain.pending", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
